// File: rtl/rx_ctrl_pkg.sv
// rx_ctrl_pkg: frame constants shared with the master's tx_ctrl, plus the receiver's FSM state types.
package rx_ctrl_pkg;
    localparam logic [7:0] SYNC_BYTE = 8'h55;
    localparam logic [7:0] BCAST_ID  = 8'hFF;
    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bstate_t;
    typedef enum logic [2:0] {F_SYNC, F_DEV, F_MOD, F_ADDR, F_DATA, F_SUM} fstate_t;
endpackage

// File: rtl/rx_ctrl_top_uart_rx_byte.sv
// uart_rx_byte: 8N1 byte deserialiser with input synchroniser; byte_vld/byte_ferr pulse in the stop-sample cycle.
module uart_rx_byte
    import rx_ctrl_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic       rx_ctrl,
    output logic [7:0] byte_data,
    output logic       byte_vld,
    output logic       byte_ferr
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);
    logic s0, s1, s2;
    logic [CW-1:0] cnt;
    logic [2:0] bit_idx;
    logic [7:0] sh;
    bstate_t bs;
    logic stop_smp;
    assign stop_smp  = (bs == B_STOP) && (cnt == FULL_M1);
    assign byte_vld  = stop_smp && s1;
    assign byte_ferr = stop_smp && !s1;
    assign byte_data = sh;
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            {s0, s1, s2} <= 3'b111;
            cnt <= '0;
            bit_idx <= '0;
            sh <= '0;
            bs <= B_IDLE;
        end else begin
            {s0, s1, s2} <= {rx_ctrl, s0, s1};
            case (bs)
                B_IDLE: begin
                    cnt <= '0;
                    if (s2 && !s1) bs <= B_START;
                end
                B_START: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == HALF_M1) begin
                        cnt <= '0;
                        bit_idx <= '0;
                        bs <= s1 ? B_IDLE : B_DATA;
                    end
                end
                B_DATA: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == FULL_M1) begin
                        cnt <= '0;
                        sh <= {s1, sh[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) bs <= B_STOP;
                    end
                end
                B_STOP: begin
                    cnt <= cnt + 1'b1;
                    if (stop_smp) begin
                        cnt <= '0;
                        bs <= B_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: rtl/rx_ctrl_top.sv
// rx_ctrl_top: RS-485 command frame receiver with device filter and inter-byte timeout.
// Define RX_CHKSUM_EN for 6-byte frames with an XOR checksum byte; otherwise frames are 5 bytes.
module rx_ctrl_top
    import rx_ctrl_pkg::*;
#(
    parameter int         BAUD_DIV = 434,
    parameter logic [7:0] DEV_ID   = 8'h01,
    parameter int         TO_BITS  = 20
) (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic       rx_ctrl,
    output logic [7:0] cmdr_dev,
    output logic [7:0] cmdr_mod,
    output logic [7:0] cmdr_addr,
    output logic [7:0] cmdr_data,
    output logic       cmdr_vld,
    output logic       rx_err,
    output logic       rx_busy
);
    localparam int TO_MAX = TO_BITS * BAUD_DIV;
    localparam int TW = $clog2(TO_MAX + 1);
    logic [7:0] byte_data, dev_sh, mod_sh, addr_sh;
    logic byte_vld, byte_ferr, dev_ok;
    logic [TW-1:0] to_cnt;
    fstate_t fs;
`ifdef RX_CHKSUM_EN
    logic [7:0] data_sh;
`endif
    uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk_sys(clk_sys), .rst(rst), .rx_ctrl(rx_ctrl),
        .byte_data(byte_data), .byte_vld(byte_vld), .byte_ferr(byte_ferr)
    );
    assign dev_ok  = (dev_sh == DEV_ID) || (dev_sh == BCAST_ID);
    assign rx_busy = fs != F_SYNC;
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            {cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data} <= '0;
            {dev_sh, mod_sh, addr_sh} <= '0;
            {cmdr_vld, rx_err} <= 2'b00;
            to_cnt <= '0;
            fs <= F_SYNC;
`ifdef RX_CHKSUM_EN
            data_sh <= '0;
`endif
        end else begin
            cmdr_vld <= 1'b0;
            rx_err <= 1'b0;
            to_cnt <= to_cnt + 1'b1;
            if (byte_ferr) begin
                to_cnt <= '0;
                rx_err <= 1'b1;
                fs <= F_SYNC;
            end else if (byte_vld) begin
                to_cnt <= '0;
                case (fs)
                    F_SYNC: fs <= (byte_data == SYNC_BYTE) ? F_DEV : F_SYNC;
                    F_DEV:  begin dev_sh <= byte_data; fs <= F_MOD; end
                    F_MOD:  begin mod_sh <= byte_data; fs <= F_ADDR; end
                    F_ADDR: begin addr_sh <= byte_data; fs <= F_DATA; end
`ifdef RX_CHKSUM_EN
                    F_DATA: begin data_sh <= byte_data; fs <= F_SUM; end
                    F_SUM: begin
                        fs <= F_SYNC;
                        if (byte_data != (dev_sh ^ mod_sh ^ addr_sh ^ data_sh)) rx_err <= 1'b1;
                        else if (dev_ok) begin
                            {cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data} <= {dev_sh, mod_sh, addr_sh, data_sh};
                            cmdr_vld <= 1'b1;
                        end
                    end
`else
                    F_DATA: begin
                        fs <= F_SYNC;
                        if (dev_ok) begin
                            {cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data} <= {dev_sh, mod_sh, addr_sh, byte_data};
                            cmdr_vld <= 1'b1;
                        end
                    end
`endif
                    default: fs <= F_SYNC;
                endcase
            end else if (fs == F_SYNC) begin
                to_cnt <= '0;
            end else if (to_cnt == TW'(TO_MAX)) begin
                to_cnt <= '0;
                rx_err <= 1'b1;
                fs <= F_SYNC;
            end
        end
    end
endmodule

// File: tb/tb_rx_ctrl_top.sv
// tb_rx_ctrl_top: scoreboard bench for rx_ctrl_top; follows RX_CHKSUM_EN to pick 5- or 6-byte frames.
module tb_rx_ctrl_top;
    localparam int BD = 16;
    typedef struct {
        logic [1:0] kind;
        logic [7:0] dev, mod, addr, data;
    } exp_t;
    logic clk_sys = 1'b0, rst = 1'b1, rx_ctrl = 1'b1;
    logic [7:0] cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data;
    logic cmdr_vld, rx_err, rx_busy;
    int vectors = 0, miscompares = 0, byte_pulses = 0;
    exp_t q[$];
    rx_ctrl_top #(.BAUD_DIV(BD), .DEV_ID(8'h01), .TO_BITS(20)) dut (
        .clk_sys(clk_sys), .rst(rst), .rx_ctrl(rx_ctrl),
        .cmdr_dev(cmdr_dev), .cmdr_mod(cmdr_mod), .cmdr_addr(cmdr_addr), .cmdr_data(cmdr_data),
        .cmdr_vld(cmdr_vld), .rx_err(rx_err), .rx_busy(rx_busy)
    );
    always #5 clk_sys = ~clk_sys;
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask
    // kind 2'b10 = accepted command, 2'b01 = error pulse
    always @(negedge clk_sys) begin
        exp_t e;
        if (dut.byte_vld) byte_pulses++;
        if (cmdr_vld || rx_err) begin
            if (q.size() == 0) check("unexpected_event", {30'd0, cmdr_vld, rx_err}, 0);
            else begin
                e = q.pop_front();
                check("event_kind", {30'd0, cmdr_vld, rx_err}, {30'd0, e.kind});
                if (e.kind == 2'b10) begin
                    check("cmdr_dev", cmdr_dev, e.dev);
                    check("cmdr_mod", cmdr_mod, e.mod);
                    check("cmdr_addr", cmdr_addr, e.addr);
                    check("cmdr_data", cmdr_data, e.data);
                end
            end
        end
    end
    task automatic bit_hold(input logic v);
        rx_ctrl = v;
        repeat (BD) @(negedge clk_sys);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bit_hold(1'b1);
    endtask
    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        bit_hold(1'b0);
        for (int i = 0; i < 8; i++) bit_hold(b[i]);
        bit_hold(stop);
    endtask
    task automatic push(input logic [1:0] k, input logic [7:0] d, m, a, x);
        exp_t e;
        e.kind = k; e.dev = d; e.mod = m; e.addr = a; e.data = x;
        q.push_back(e);
    endtask
    task automatic send_frame(input logic [7:0] d, m, a, x, input logic [7:0] delta = 8'h00);
        logic ok;
        ok = (d == 8'h01) || (d == 8'hFF);
`ifdef RX_CHKSUM_EN
        if (delta != 8'h00) push(2'b01, 0, 0, 0, 0);
        else if (ok) push(2'b10, d, m, a, x);
`else
        if (ok) push(2'b10, d, m, a, x);
`endif
        send_byte(8'h55);
        send_byte(d);
        send_byte(m);
        send_byte(a);
        send_byte(x);
`ifdef RX_CHKSUM_EN
        send_byte(d ^ m ^ a ^ x ^ delta);
`endif
    endtask
    task automatic check_reset_state(input string tag);
        check({tag, "_dev"}, cmdr_dev, 0);
        check({tag, "_mod"}, cmdr_mod, 0);
        check({tag, "_addr"}, cmdr_addr, 0);
        check({tag, "_data"}, cmdr_data, 0);
        check({tag, "_vld"}, {31'd0, cmdr_vld}, 0);
        check({tag, "_err"}, {31'd0, rx_err}, 0);
        check({tag, "_busy"}, {31'd0, rx_busy}, 0);
    endtask
    initial begin
        int p;
        repeat (4) @(negedge clk_sys);
        rst = 1'b0;
        @(negedge clk_sys);
        check_reset_state("reset");
        idle(2);
        send_frame(8'h01, 8'h02, 8'h10, 8'hA7);
        send_frame(8'hFF, 8'h11, 8'h22, 8'h33);
        send_frame(8'h03, 8'h44, 8'h55, 8'h66);
        send_frame(8'h01, 8'h05, 8'h06, 8'h07);
`ifdef RX_CHKSUM_EN
        send_frame(8'h01, 8'h02, 8'h10, 8'hA7, 8'h01);
        send_frame(8'h01, 8'h0A, 8'h0B, 8'h0C);
`endif
        idle(2);
        push(2'b01, 0, 0, 0, 0);
        send_byte(8'h55);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h10, 1'b0);
        idle(2);
        check("busy_after_ferr", {31'd0, rx_busy}, 0);
        push(2'b01, 0, 0, 0, 0);
        send_byte(8'h55);
        send_byte(8'h01);
        send_byte(8'h02);
        check("busy_mid_frame", {31'd0, rx_busy}, 1);
        idle(21);
        check("busy_after_timeout", {31'd0, rx_busy}, 0);
        send_byte(8'h00);
        send_byte(8'h3C);
        send_frame(8'h01, 8'h21, 8'h43, 8'h65);
        idle(2);
        p = byte_pulses;
        rx_ctrl = 1'b0;
        @(negedge clk_sys);
        idle(4);
        check("glitch_bytes", byte_pulses - p, 0);
        check("glitch_busy", {31'd0, rx_busy}, 0);
        send_byte(8'h55);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h10);
        rst = 1'b1;
        @(negedge clk_sys);
        rst = 1'b0;
        @(negedge clk_sys);
        check_reset_state("midrst");
        send_byte(8'hA7);
`ifdef RX_CHKSUM_EN
        send_byte(8'hB4);
`endif
        idle(25);
        check("pending_events", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
